// File: rtl/damage_dispatcher.sv
// Two-channel buffered damage dispatcher: per-channel FIFO of {target, amount} drained onto a
// registered one-cycle damage pulse bus. Optional drop counters with `define DAMAGE_DROP_CNT_EN.
module damage_dispatcher #(
    parameter int NUM_UNITS  = 16,
    parameter int DMG_W      = 9,
    parameter int SEL_W      = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       apply_en,
    input  logic                       u_req_valid,
    output logic                       u_req_ready,
    input  logic [SEL_W-1:0]           u_req_target,
    input  logic [DMG_W-1:0]           u_req_amount,
    input  logic                       e_req_valid,
    output logic                       e_req_ready,
    input  logic [SEL_W-1:0]           e_req_target,
    input  logic [DMG_W-1:0]           e_req_amount,
    output logic [NUM_UNITS*DMG_W-1:0] enemy_applied_dmg,
    output logic [DMG_W-1:0]           enemy_tower_dmg,
    output logic [NUM_UNITS*DMG_W-1:0] unit_applied_dmg,
    output logic [DMG_W-1:0]           friendly_tower_dmg,
    output logic                       u_applied_valid,
    output logic                       e_applied_valid,
    output logic                       busy
`ifdef DAMAGE_DROP_CNT_EN
    ,
    output logic [7:0]                 u_drop_cnt,
    output logic [7:0]                 e_drop_cnt
`endif
);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int ENTRY_W = SEL_W + DMG_W;
    localparam int BUS_W   = (NUM_UNITS + 1) * DMG_W;

    // Channel 0 carries friendly-dealt damage, channel 1 enemy-dealt damage.
    logic [1:0]               req_valid;
    logic [1:0][ENTRY_W-1:0]  req_entry;
    logic [1:0]               push, pop, full, empty;
    logic [1:0][ENTRY_W-1:0]  head;
    logic [1:0][SEL_W-1:0]    head_tgt;
    logic [1:0][DMG_W-1:0]    head_amt;
    logic [ENTRY_W-1:0]       mem_q [2][FIFO_DEPTH];
    logic [ENTRY_W-1:0]       mem_d [2][FIFO_DEPTH];
    logic [1:0][PTR_W:0]      wr_ptr_q, wr_ptr_d;
    logic [1:0][PTR_W:0]      rd_ptr_q, rd_ptr_d;
    logic [1:0][BUS_W-1:0]    bus_q, bus_d;
    logic [1:0]               vld_q, vld_d;

`ifdef DAMAGE_DROP_CNT_EN
    logic [1:0][7:0]          drop_cnt_q, drop_cnt_d;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction
`endif

    always_comb begin
        req_valid    = {e_req_valid, u_req_valid};
        req_entry[0] = {u_req_target, u_req_amount};
        req_entry[1] = {e_req_target, e_req_amount};
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        bus_d        = '0;
        vld_d        = '0;
        push         = '0;
        pop          = '0;
        full         = '0;
        empty        = '0;
        head         = '0;
        head_tgt     = '0;
        head_amt     = '0;
`ifdef DAMAGE_DROP_CNT_EN
        drop_cnt_d   = drop_cnt_q;
`endif
        for (int c = 0; c < 2; c++) begin
            empty[c]    = (wr_ptr_q[c] == rd_ptr_q[c]);
            full[c]     = (wr_ptr_q[c][PTR_W-1:0] == rd_ptr_q[c][PTR_W-1:0]) &&
                          (wr_ptr_q[c][PTR_W] != rd_ptr_q[c][PTR_W]);
            push[c]     = req_valid[c] && !full[c];
            pop[c]      = apply_en && !empty[c];
            head[c]     = mem_q[c][rd_ptr_q[c][PTR_W-1:0]];
            head_tgt[c] = head[c][ENTRY_W-1 -: SEL_W];
            head_amt[c] = head[c][DMG_W-1:0];

            if (push[c]) begin
                mem_d[c][wr_ptr_q[c][PTR_W-1:0]] = req_entry[c];
                wr_ptr_d[c] = wr_ptr_q[c] + 1'b1;
            end

            if (pop[c]) begin
                rd_ptr_d[c] = rd_ptr_q[c] + 1'b1;
                // Index NUM_UNITS is the tower slot, placed just above the unit slices.
                if (head_tgt[c] <= SEL_W'(NUM_UNITS)) begin
                    vld_d[c] = 1'b1;
                    for (int i = 0; i <= NUM_UNITS; i++) begin
                        if (head_tgt[c] == SEL_W'(i)) begin
                            bus_d[c][i*DMG_W +: DMG_W] = head_amt[c];
                        end
                    end
                end else begin
`ifdef DAMAGE_DROP_CNT_EN
                    drop_cnt_d[c] = sat_inc(drop_cnt_q[c]);
`else
                    // Out-of-range entries are consumed with no trace.
`endif
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            bus_q    <= '0;
            vld_q    <= '0;
`ifdef DAMAGE_DROP_CNT_EN
            drop_cnt_q <= '0;
`endif
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            bus_q    <= bus_d;
            vld_q    <= vld_d;
`ifdef DAMAGE_DROP_CNT_EN
            drop_cnt_q <= drop_cnt_d;
`endif
        end
        mem_q <= mem_d;
    end

    assign u_req_ready        = !full[0];
    assign e_req_ready        = !full[1];
    assign busy               = !empty[0] || !empty[1];
    assign enemy_applied_dmg  = bus_q[0][NUM_UNITS*DMG_W-1:0];
    assign enemy_tower_dmg    = bus_q[0][NUM_UNITS*DMG_W +: DMG_W];
    assign unit_applied_dmg   = bus_q[1][NUM_UNITS*DMG_W-1:0];
    assign friendly_tower_dmg = bus_q[1][NUM_UNITS*DMG_W +: DMG_W];
    assign u_applied_valid    = vld_q[0];
    assign e_applied_valid    = vld_q[1];
`ifdef DAMAGE_DROP_CNT_EN
    assign u_drop_cnt         = drop_cnt_q[0];
    assign e_drop_cnt         = drop_cnt_q[1];
`endif

endmodule

// File: tb/tb_damage_dispatcher.sv
// Directed bench for damage_dispatcher with hand-computed expectations and immediate assertions.
// Drop-counter checks are compiled in when DAMAGE_DROP_CNT_EN is defined.
module tb_damage_dispatcher;
    localparam int NU = 16;
    localparam int DW = 9;
    localparam int SW = 5;

    logic              Clk = 1'b0;
    logic              Reset;
    logic              apply_en;
    logic              u_req_valid, u_req_ready;
    logic [SW-1:0]     u_req_target;
    logic [DW-1:0]     u_req_amount;
    logic              e_req_valid, e_req_ready;
    logic [SW-1:0]     e_req_target;
    logic [DW-1:0]     e_req_amount;
    logic [NU*DW-1:0]  enemy_applied_dmg, unit_applied_dmg;
    logic [DW-1:0]     enemy_tower_dmg, friendly_tower_dmg;
    logic              u_applied_valid, e_applied_valid, busy;
`ifdef DAMAGE_DROP_CNT_EN
    logic [7:0]        u_drop_cnt, e_drop_cnt;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 Clk = ~Clk;

    damage_dispatcher #(.NUM_UNITS(NU), .DMG_W(DW), .SEL_W(SW), .FIFO_DEPTH(4)) dut (
        .Clk(Clk), .Reset(Reset), .apply_en(apply_en),
        .u_req_valid(u_req_valid), .u_req_ready(u_req_ready),
        .u_req_target(u_req_target), .u_req_amount(u_req_amount),
        .e_req_valid(e_req_valid), .e_req_ready(e_req_ready),
        .e_req_target(e_req_target), .e_req_amount(e_req_amount),
        .enemy_applied_dmg(enemy_applied_dmg), .enemy_tower_dmg(enemy_tower_dmg),
        .unit_applied_dmg(unit_applied_dmg), .friendly_tower_dmg(friendly_tower_dmg),
        .u_applied_valid(u_applied_valid), .e_applied_valid(e_applied_valid),
        .busy(busy)
`ifdef DAMAGE_DROP_CNT_EN
        , .u_drop_cnt(u_drop_cnt), .e_drop_cnt(e_drop_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [NU*DW-1:0] slice_at(input int t, input int a);
        logic [NU*DW-1:0] v;
        v = '0;
        if (t < NU) v[t*DW +: DW] = DW'(a);
        return v;
    endfunction

    task automatic drive_u(input logic v, input int t, input int a);
        u_req_valid  = v;
        u_req_target = SW'(t);
        u_req_amount = DW'(a);
    endtask

    task automatic drive_e(input logic v, input int t, input int a);
        e_req_valid  = v;
        e_req_target = SW'(t);
        e_req_amount = DW'(a);
    endtask

    task automatic chk_u(input string tag, input logic v, input int t, input int a);
        chk({tag, "_uvld"}, u_applied_valid, v);
        chk({tag, "_ubus"}, enemy_applied_dmg, v ? slice_at(t, a) : '0);
        chk({tag, "_utwr"}, enemy_tower_dmg, (v && t == NU) ? DW'(a) : '0);
    endtask

    task automatic chk_e(input string tag, input logic v, input int t, input int a);
        chk({tag, "_evld"}, e_applied_valid, v);
        chk({tag, "_ebus"}, unit_applied_dmg, v ? slice_at(t, a) : '0);
        chk({tag, "_etwr"}, friendly_tower_dmg, (v && t == NU) ? DW'(a) : '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int q_t[$];
        int q_a[$];
        int nt, na, et, ea, acc;

        Reset = 1'b1;
        apply_en = 1'b0;
        drive_u(1'b0, 0, 0);
        drive_e(1'b0, 0, 0);
        step();
        step();
        chk("rst_uready", u_req_ready, 1'b1);
        chk("rst_eready", e_req_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk_u("rst", 1'b0, 0, 0);
        chk_e("rst", 1'b0, 0, 0);
        Reset = 1'b0;
        apply_en = 1'b1;
        step();

        // Single friendly-dealt hit on enemy unit 3.
        drive_u(1'b1, 3, 255);
        step();
        drive_u(1'b0, 0, 0);
        chk("t1_busy", busy, 1'b1);
        chk_u("t1_lat1", 1'b0, 0, 0);
        step();
        chk_u("t1_pulse", 1'b1, 3, 255);
        step();
        chk_u("t1_after", 1'b0, 0, 0);
        chk("t1_idle", busy, 1'b0);

        // Enemy hits the friendly tower.
        drive_e(1'b1, 16, 100);
        step();
        drive_e(1'b0, 0, 0);
        step();
        chk_e("t2_tower", 1'b1, 16, 100);
        chk_u("t2_uquiet", 1'b0, 0, 0);
        step();
        chk_e("t2_after", 1'b0, 0, 0);

        // Both channels in the same cycle, then a zero-amount hit.
        drive_u(1'b1, 2, 7);
        drive_e(1'b1, 0, 9);
        step();
        drive_u(1'b1, 5, 0);
        drive_e(1'b0, 0, 0);
        step();
        drive_u(1'b0, 0, 0);
        chk_u("t2b_both", 1'b1, 2, 7);
        chk_e("t2b_both", 1'b1, 0, 9);
        step();
        chk_u("t2c_zero", 1'b1, 5, 0);
        chk_e("t2c_equiet", 1'b0, 0, 0);
        step();

        // Fill with apply_en low, then drain in order.
        apply_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_u(1'b1, i, (i + 1) * 10);
            chk("t3_ready_fill", u_req_ready, 1'b1);
            step();
            chk("t3_novld_fill", u_applied_valid, 1'b0);
        end
        chk("t3_full", u_req_ready, 1'b0);
        drive_u(1'b1, 4, 50);
        step();
        chk("t3_stalled", u_req_ready, 1'b0);
        chk_u("t3_hold", 1'b0, 0, 0);
        apply_en = 1'b1;
        step();
        chk_u("t3_p0", 1'b1, 0, 10);
        chk("t3_ready_back", u_req_ready, 1'b1);
        step();
        drive_u(1'b0, 0, 0);
        chk_u("t3_p1", 1'b1, 1, 20);
        step();
        chk_u("t3_p2", 1'b1, 2, 30);
        step();
        chk_u("t3_p3", 1'b1, 3, 40);
        step();
        chk_u("t3_p4", 1'b1, 4, 50);
        step();
        chk_u("t3_done", 1'b0, 0, 0);
        chk("t3_busy", busy, 1'b0);

        // Full FIFO with concurrent push/pop, scoreboarded.
        apply_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_u(1'b1, 5 + i, i + 1);
            step();
            q_t.push_back(5 + i);
            q_a.push_back(i + 1);
        end
        chk("t4_full", u_req_ready, 1'b0);
        nt = 9;
        na = 5;
        drive_u(1'b1, nt, na);
        apply_en = 1'b1;
        for (int c = 0; c < 6; c++) begin
            acc = int'(u_req_ready);
            step();
            et = q_t.pop_front();
            ea = q_a.pop_front();
            chk_u("t4_flow", 1'b1, et, ea);
            chk("t4_busy", busy, 1'b1);
            if (acc != 0) begin
                q_t.push_back(nt);
                q_a.push_back(na);
                nt++;
                na++;
                drive_u(1'b1, nt, na);
            end
        end
        drive_u(1'b0, 0, 0);
        for (int c = 0; c < 8 && q_t.size() > 0; c++) begin
            step();
            et = q_t.pop_front();
            ea = q_a.pop_front();
            chk_u("t4_drain", 1'b1, et, ea);
        end
        chk("t4_empty_q", q_t.size(), 0);
        step();
        chk("t4_idle", busy, 1'b0);

        // Out-of-range targets are consumed silently.
        drive_u(1'b1, 20, 50);
        step();
        drive_u(1'b1, 17, 5);
        step();
        drive_u(1'b0, 0, 0);
        chk_u("t5_bad20", 1'b0, 0, 0);
`ifdef DAMAGE_DROP_CNT_EN
        chk("t5_drop1", u_drop_cnt, 8'd1);
`endif
        step();
        chk_u("t5_bad17", 1'b0, 0, 0);
        chk("t5_busy", busy, 1'b0);
`ifdef DAMAGE_DROP_CNT_EN
        chk("t5_drop2", u_drop_cnt, 8'd2);
        chk("t5_edrop", e_drop_cnt, 8'd0);
        acc = 0;
        drive_u(1'b1, 31, 1);
        for (int c = 0; c < 400 && acc < 300; c++) begin
            if (u_req_ready) acc++;
            step();
            chk("t5_sat_vld", u_applied_valid, 1'b0);
        end
        drive_u(1'b0, 0, 0);
        chk("t5_accepted", acc, 300);
        for (int c = 0; c < 6; c++) step();
        chk("t5_drop_sat", u_drop_cnt, 8'd255);
`endif

        // Reset while entries are queued.
        apply_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_u(1'b1, 7, 11 + i);
            step();
        end
        drive_u(1'b0, 0, 0);
        chk("t6_busy_pre", busy, 1'b1);
        apply_en = 1'b1;
        Reset = 1'b1;
        step();
        chk("t6_busy_rst", busy, 1'b0);
        chk("t6_ready_rst", u_req_ready, 1'b1);
        chk_u("t6_rst", 1'b0, 0, 0);
`ifdef DAMAGE_DROP_CNT_EN
        chk("t6_drop_rst", u_drop_cnt, 8'd0);
`endif
        Reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            chk_u("t6_quiet", 1'b0, 0, 0);
            chk("t6_busy", busy, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
